// File: rtl/ramp_pkg.sv
// ramp_pkg: shared types, default sizes and saturation helper for lane_ramp_gen
//   DEF_WIDTH / DEF_LANES / DEF_CNT_W : default lane width, lanes per beat, count width
//   lane_t  : signed lane value
//   wide_t  : signed exact-value width (lane width + count width + 1)
//   mode_e  : per-command overflow handling
//   state_e : command FSM state
//   sat_clamp : clamp a wide value into the signed range of a w-bit lane
package ramp_pkg;
    localparam int DEF_WIDTH = 19;
    localparam int DEF_LANES = 64;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_WIDE  = DEF_WIDTH + DEF_CNT_W + 1;

    typedef logic signed [DEF_WIDTH-1:0] lane_t;
    typedef logic signed [DEF_WIDE-1:0]  wide_t;
    typedef enum logic {RAMP_WRAP = 1'b0, RAMP_SAT = 1'b1} mode_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    function automatic wide_t sat_clamp(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = ~hi;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction
endpackage

// File: rtl/lane_ramp_row.sv
// lane_ramp_row: combinational generator of one beat of ramp values
//   cur       in  : exact value of lane 0 for this beat
//   step      in  : signed increment between lanes
//   remaining in  : values still owed by the command (lanes at or past it are empty)
//   mode      in  : wrap or saturate
//   data      out : LANES lane values, zero where the lane is empty
//   mask      out : bit i set iff lane i holds a real value
module lane_ramp_row
    import ramp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic signed [WIDTH+CNT_W:0] cur,
    input  logic signed [WIDTH-1:0]     step,
    input  logic        [CNT_W-1:0]     remaining,
    input  mode_e                       mode,
    output logic signed [WIDTH-1:0]     data [0:LANES-1],
    output logic        [LANES-1:0]     mask
);
    localparam int WW = WIDTH + CNT_W + 1;
    // Group size picked so that group offsets and in-group increments stay short adders
    localparam int G  = (LANES >= 64) ? 8 : ((LANES >= 16) ? 4 : 2);
    localparam int NG = LANES / G;

    logic signed [WW-1:0] step_w;

    assign step_w = {{(WW-WIDTH){step[WIDTH-1]}}, step};

    for (genvar g = 0; g < NG; g++) begin : grp
        localparam logic signed [WW-1:0] GOFF = WW'(g * G);
        logic signed [WW-1:0] base_g;
        assign base_g = cur + step_w * GOFF;
        for (genvar j = 0; j < G; j++) begin : lane
            localparam int I = g * G + j;
            localparam logic signed [WW-1:0] JOFF = WW'(j);
            localparam logic [CNT_W-1:0] IDX = CNT_W'(I);
            logic signed [WW-1:0]    sum;
            logic signed [WIDTH-1:0] sat_v;
            assign sum     = base_g + step_w * JOFF;
            assign sat_v   = WIDTH'(sat_clamp(wide_t'(sum), WIDTH));
            assign mask[I] = IDX < remaining;
            assign data[I] = !mask[I] ? '0 : ((mode == RAMP_SAT) ? sat_v : sum[WIDTH-1:0]);
        end
    end
endmodule

// File: rtl/lane_ramp_gen.sv
// lane_ramp_gen: streams count values base + k*step, LANES per beat, wrap or saturate
//   clk, reset      : clock, asynchronous active-high reset
//   start_valid/ready, base, step, count, mode : command handshake and fields
//   out_valid/ready : beat handshake
//   out_data, out_mask, out_last, out_beat     : beat lanes, lane mask, final-beat flag, beat index
module lane_ramp_gen
    import ramp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] step,
    input  logic        [CNT_W-1:0] count,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data [0:LANES-1],
    output logic        [LANES-1:0] out_mask,
    output logic                    out_last,
    output logic        [CNT_W-1:0] out_beat
);
    localparam int WW = WIDTH + CNT_W + 1;
    localparam logic signed [WW-1:0] LANES_W = WW'(LANES);
    localparam logic        [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    state_e                  state;
    state_e                  state_nxt;
    logic signed [WW-1:0]    cur;
    logic signed [WW-1:0]    cur_nxt;
    logic signed [WW-1:0]    step_w;
    logic signed [WIDTH-1:0] step_r;
    logic signed [WIDTH-1:0] step_nxt;
    mode_e                   mode_r;
    mode_e                   mode_nxt;
    logic        [CNT_W-1:0] rem;
    logic        [CNT_W-1:0] rem_nxt;
    logic                    accept;
    logic                    fire;
    logic                    load;
    logic signed [WIDTH-1:0] row_data [0:LANES-1];
    logic        [LANES-1:0] row_mask;

    assign accept = start_valid && start_ready;
    assign fire   = out_valid && out_ready;
    assign step_w = {{(WW-WIDTH){step_r[WIDTH-1]}}, step_r};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-count command is consumed in IDLE without ever leaving it
    always_comb begin
        state_nxt = (state == ST_IDLE) ? ((accept && count != '0) ? ST_RUN : ST_IDLE)
                                       : ((fire && out_last) ? ST_IDLE : ST_RUN);
        load      = (state == ST_IDLE) ? (accept && count != '0) : (fire && !out_last);
    end

    // The row generator works on the values of the beat about to be registered
    always_comb begin
        cur_nxt  = accept ? {{(WW-WIDTH){base[WIDTH-1]}}, base} : cur + step_w * LANES_W;
        step_nxt = accept ? step : step_r;
        mode_nxt = accept ? mode_e'(mode) : mode_r;
        rem_nxt  = accept ? count : rem - LANES_C;
    end

    lane_ramp_row #(
        .WIDTH(WIDTH),
        .LANES(LANES),
        .CNT_W(CNT_W)
    ) u_row (
        .cur(cur_nxt),
        .step(step_nxt),
        .remaining(rem_nxt),
        .mode(mode_nxt),
        .data(row_data),
        .mask(row_mask)
    );

    // start_ready is registered so it stays low through reset and never follows the handshakes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_ready <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_beat    <= '0;
            out_mask    <= '0;
            out_data    <= '{default: '0};
            cur         <= '0;
            step_r      <= '0;
            mode_r      <= RAMP_WRAP;
            rem         <= '0;
        end else begin
            start_ready <= state_nxt == ST_IDLE;
            if (accept || fire) begin
                cur <= cur_nxt;
                rem <= rem_nxt;
            end
            if (accept) begin
                step_r <= step;
                mode_r <= mode_nxt;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= row_data;
                out_mask  <= row_mask;
                out_last  <= rem_nxt <= LANES_C;
                out_beat  <= accept ? '0 : out_beat + CNT_W'(1);
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lane_ramp_gen.sv
// tb_lane_ramp_gen: directed and randomized checks of lane_ramp_gen against an arithmetic model
module tb_lane_ramp_gen;
    localparam int WIDTH = 19;
    localparam int LANES = 64;
    localparam int CNT_W = 16;

    typedef logic signed [63:0] v64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start_valid;
    logic                    start_ready;
    logic signed [WIDTH-1:0] base;
    logic signed [WIDTH-1:0] step;
    logic        [CNT_W-1:0] count;
    logic                    mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data [0:LANES-1];
    logic        [LANES-1:0] out_mask;
    logic                    out_last;
    logic        [CNT_W-1:0] out_beat;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    v64 cap  [0:LANES-1];
    v64 capl [0:LANES-1];

    always #5 clk = ~clk;

    lane_ramp_gen #(
        .WIDTH(WIDTH),
        .LANES(LANES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .base(base),
        .step(step),
        .count(count),
        .mode(mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_mask(out_mask),
        .out_last(out_last),
        .out_beat(out_beat)
    );

    function automatic v64 model(input longint b, input longint s, input longint k, input bit sat);
        longint v;
        longint hi;
        v  = b + k * s;
        hi = (64'sd1 <<< (WIDTH - 1)) - 1;
        if (sat) return (v > hi) ? hi : ((v < -hi - 1) ? -hi - 1 : v);
        v = v & ((64'sd1 <<< WIDTH) - 1);
        return (v > hi) ? v - (64'sd1 <<< WIDTH) : v;
    endfunction

    task automatic chk(input string tag, input v64 obs, input v64 exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%h), expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_beat(input string tag, input longint b, input longint s, input int n,
                              input bit sat, input int bt);
        int nb;
        int bad;
        int idx;
        v64 exp [0:LANES-1];
        logic [LANES-1:0] emask;
        nb  = (n + LANES - 1) / LANES;
        bad = -1;
        for (int i = 0; i < LANES; i++) begin
            emask[i] = (bt * LANES + i) < n;
            exp[i]   = emask[i] ? model(b, s, longint'(bt * LANES + i), sat) : v64'(0);
            if (bad < 0 && v64'(out_data[i]) !== exp[i]) bad = i;
        end
        idx = (bad < 0) ? 0 : bad;
        chk($sformatf("%s beat%0d out_valid", tag, bt), v64'(out_valid), 1);
        chk($sformatf("%s beat%0d out_beat", tag, bt), v64'(out_beat), v64'(bt));
        chk($sformatf("%s beat%0d out_last", tag, bt), v64'(out_last), v64'(bt == nb - 1));
        chk($sformatf("%s beat%0d out_mask", tag, bt), v64'(out_mask), v64'(emask));
        chk($sformatf("%s beat%0d lane%0d", tag, bt, idx), v64'(out_data[idx]), exp[idx]);
        for (int i = 0; i < LANES; i++) begin
            if (bt == 0) cap[i] = v64'(out_data[i]);
            if (bt == nb - 1) capl[i] = v64'(out_data[i]);
        end
    endtask

    task automatic run_cmd(input string tag, input longint b, input longint s, input int n,
                           input bit sat, input int stall_beat, input int stall_len);
        int nb;
        nb = (n + LANES - 1) / LANES;
        @(negedge clk);
        chk({tag, " start_ready before"}, v64'(start_ready), 1);
        start_valid = 1'b1;
        base        = WIDTH'(b);
        step        = WIDTH'(s);
        count       = CNT_W'(n);
        mode        = sat;
        out_ready   = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        base        = WIDTH'($urandom);
        step        = WIDTH'($urandom);
        count       = CNT_W'($urandom);
        mode        = ~sat;
        if (n == 0) begin
            chk({tag, " zero out_valid"}, v64'(out_valid), 0);
            chk({tag, " zero start_ready"}, v64'(start_ready), 1);
            @(negedge clk);
            chk({tag, " zero out_valid later"}, v64'(out_valid), 0);
            return;
        end
        for (int bt = 0; bt < nb; bt++) begin
            check_beat(tag, b, s, n, sat, bt);
            if (bt == stall_beat) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check_beat({tag, " stall"}, b, s, n, sat, bt);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk({tag, " end out_valid"}, v64'(out_valid), 0);
        chk({tag, " end start_ready"}, v64'(start_ready), 1);
    endtask

    initial begin
        logic signed [WIDTH-1:0] rb;
        logic signed [WIDTH-1:0] rs;
        reset       = 1'b1;
        start_valid = 1'b0;
        out_ready   = 1'b0;
        base        = '0;
        step        = '0;
        count       = '0;
        mode        = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset start_ready", v64'(start_ready), 0);
        chk("reset out_valid", v64'(out_valid), 0);
        chk("reset out_last", v64'(out_last), 0);
        chk("reset out_beat", v64'(out_beat), 0);
        chk("reset out_mask", v64'(out_mask), 0);
        chk("reset out_data0", v64'(out_data[0]), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset start_ready", v64'(start_ready), 1);

        run_cmd("full", 0, 1, 64, 1'b0, -1, 0);
        chk("full lane63", cap[63], 63);

        run_cmd("partial", -100, 3, 130, 1'b0, -1, 0);
        chk("partial last lane0", capl[0], 284);
        chk("partial last lane1", capl[1], 287);
        chk("partial last lane2", capl[2], 0);

        run_cmd("sat", 262000, 100, 64, 1'b1, -1, 0);
        chk("sat lane1", cap[1], 262100);
        chk("sat lane2", cap[2], 262143);
        chk("sat lane63", cap[63], 262143);

        run_cmd("wrap", 262000, 100, 64, 1'b0, -1, 0);
        chk("wrap lane2", cap[2], -262088);

        run_cmd("stall", 7, -5, 150, 1'b0, 1, 5);
        run_cmd("zero", 1, 1, 0, 1'b0, -1, 0);
        run_cmd("extreme sat", -262144, -262144, 4000, 1'b1, 10, 2);
        run_cmd("extreme wrap", 262143, 262143, 700, 1'b0, 3, 1);

        @(negedge clk);
        start_valid = 1'b1;
        base        = -19'sd100;
        step        = 19'sd3;
        count       = 16'd130;
        mode        = 1'b0;
        out_ready   = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        chk("rst-run beat0 valid", v64'(out_valid), 1);
        @(negedge clk);
        chk("rst-run beat1 index", v64'(out_beat), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst-run out_valid drop", v64'(out_valid), 0);
        chk("rst-run out_mask drop", v64'(out_mask), 0);
        chk("rst-run start_ready low", v64'(start_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst-run start_ready after", v64'(start_ready), 1);
        chk("rst-run out_valid after", v64'(out_valid), 0);
        run_cmd("after reset", 5, -7, 70, 1'b0, -1, 0);

        for (int r = 0; r < 25; r++) begin
            rb = WIDTH'($urandom);
            rs = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 40)) - 19'sd20;
            run_cmd($sformatf("rand%0d", r), longint'(rb), longint'(rs), int'($urandom_range(0, 300)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/lane_ramp_gen.md
# lane_ramp_gen

Streaming, parametrised successor to the fixed 64-output linear adder tree. It accepts a command (base, step, count, mode) and emits `count` arithmetic-progression values `base + k*step`, `LANES` values per beat. Beats use a valid/ready handshake. Wrap or saturate overflow handling is selectable per command. It sits between the per-row coordinate setup logic and the per-pixel compute lanes.

## Interface
- `WIDTH`, 19: lane value width, signed two's complement.
- `LANES`, 64: values per beat; power of two, ≥2.
- `CNT_W`, 16: width of `count` and the beat index.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start_valid` in 1: command valid.
- `start_ready` out 1: command accepted when high with `start_valid`.
- `base` in WIDTH: signed start value.
- `step` in WIDTH: signed increment.
- `count` in CNT_W: unsigned number of values to emit.
- `mode` in 1: 0 = wrap (truncate), 1 = saturate.
- `out_valid` out 1: beat valid.
- `out_ready` in 1: consumer accepts beat.
- `out_data` out LANES×WIDTH: signed lane values, unpacked `[0:LANES-1]`.
- `out_mask` out LANES: bit i set iff lane i holds a real value.
- `out_last` out 1: final beat of the command.
- `out_beat` out CNT_W: beat index within the command, from 0.

## Operation
- FSM has two states:
  - IDLE: `start_ready`=1.
  - RUN: `start_ready`=0.
- Accepting a command in IDLE:
  - latch `step` and `mode`;
  - set `cur = base` (sign-extended) and `remaining = count`.
- If `count`=0: the command is consumed, no beat is emitted, and the FSM stays in IDLE.
- Otherwise the FSM enters RUN with beat 0 registered.
- Beat content, lanes i < min(LANES, remaining):
  - `out_data[i] = f(cur + i*step)`; `out_mask[i]`=1.
  - Lanes at or beyond that bound drive 0 with mask 0.
- `out_last`=1 iff `remaining` ≤ LANES.
- On a handshake (`out_valid && out_ready`):
  - `cur += LANES*step`;
  - `remaining -= LANES`;
  - `out_beat += 1`;
  - register the next beat.
  - If `out_last` was set, return to IDLE with `out_valid`=0.
- Stall: when `out_valid && !out_ready`, all `out_*` are held bit-stable.
- Arithmetic:
  - `cur` and the lane sums are held at `WIDTH+CNT_W+1` bits signed, so the exact value never overflows internally.
  - Wrap mode keeps the low `WIDTH` bits.
  - Saturate mode clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Mode is per command; a change mid-run is ignored until the next accept.
- Reset values:
  - `start_ready`=0 while `reset` is high, then 1 in IDLE.
  - `out_valid`, `out_last`, `out_beat`, `out_mask`, `out_data` = 0.
  - FSM goes to IDLE; a command in flight is discarded.

## Timing
- Command accepted at edge N: beat 0 is valid after edge N (one-cycle latency).
- With `out_ready` held high, throughput is one beat per cycle; beats = ceil(count/LANES).
- Last handshake at edge M: `out_valid`=0 and `start_ready`=1 after M. The next command can be accepted at edge M+1, giving a one-cycle bubble between commands.
- `start_ready` depends only on state and never combinationally on `start_valid` or `out_ready`.
- Asynchronous reset mid-beat: outputs drop immediately without waiting for a clock edge.

## Structure
- Package `ramp_pkg` holds:
  - `lane_t` (signed WIDTH), `wide_t` (signed WIDTH+CNT_W+1), `mode_e` {RAMP_WRAP, RAMP_SAT};
  - the FSM state enum;
  - the `sat_clamp` function.
- Sub-module `lane_ramp_row` is combinational:
  - inputs: `cur`, `step`, `remaining`, `mode`;
  - outputs: the LANES values and the mask;
  - it uses a blocked adder structure (group offsets plus in-group increments).
- The top level holds the FSM, counters and output registers.

## Test plan
All scenarios use default parameters.

- **Single full beat:** base=0, step=1, count=64, wrap.
  - Exactly one beat, `out_valid` 1 cycle after accept.
  - `out_data[i]`=i, mask all ones, `out_last`=1, `out_beat`=0.
- **Partial last beat:** base=−100, step=3, count=130.
  - Three beats with `out_beat` 0,1,2.
  - Beat 2 lanes 0,1 = 284, 287; mask = 0x3; lanes 2–63 = 0; `out_last` only on beat 2.
- **Overflow handling:** base=262000, step=100, count=64.
  - Saturate: lane 1 = 262100, lanes 2–63 = 262143.
  - Wrap: lane 2 = −262088.
- **Backpressure:** `out_ready` low 5 cycles while beat 1 is valid.
  - Outputs bit-stable throughout; beat 2 appears 1 cycle after the handshake.
- **Zero count:** count=0 accepted.
  - `out_valid` never rises; `start_ready`=1 on the following cycle.
- **Reset mid-run:** `reset` pulsed during beat 1 of a 3-beat command.
  - `out_valid`=0 immediately; `start_ready`=1 after release.
  - A new command then produces correct beat 0.
